alu_op_sequencer: RTL and testbench

Multi-cycle operand-fetch / writeback sequencer sitting directly upstream of the combinational ALU (a, b, 3-bit ALUControl -> result).
- Accepts one operation request at a time over a valid/ready handshake.
- Reads operands from an internal register file and drives the ALU inputs from registers.
- Captures the ALU result, writes it back to the destination register and reports completion.

---
 rtl/alu_op_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: operand-fetch / writeback sequencer placed upstream of a combinational ALU.
// Accepts one request at a time (valid/ready), reads operands from an internal register file,
// drives registered operands/control to the ALU, captures the result and writes it back.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready             request handshake (req_ready is registered)
//   req_op/rs1/rs2/imm_en/imm/rd    request fields, sampled only on acceptance
//   alu_a/alu_b/alu_ctrl            registered ALU operands and ALUControl
//   alu_result                      combinational result returned by the ALU
//   done_valid/done_data/done_err   one-cycle completion pulse, captured result, illegal-op flag
//   cfg_we/cfg_addr/cfg_data        register-file preload port
//   dbg_addr/dbg_data               combinational register-file read port (r0 reads 0)
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [$clog2(NREG)-1:0]  req_rs1,
  input  logic [$clog2(NREG)-1:0]  req_rs2,
  input  logic                     req_imm_en,
  input  logic [WIDTH-1:0]         req_imm,
  input  logic [$clog2(NREG)-1:0]  req_rd,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_ctrl,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     done_valid,
  output logic [WIDTH-1:0]         done_data,
  output logic                     done_err,
  input  logic                     cfg_we,
  input  logic [$clog2(NREG)-1:0]  cfg_addr,
  input  logic [WIDTH-1:0]         cfg_data,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    rs1_q, rs1_d;
  logic [AW-1:0]    rs2_q, rs2_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic             imm_en_q, imm_en_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic             done_valid_q, done_valid_d;
  logic [WIDTH-1:0] done_data_q, done_data_d;
  logic             done_err_q, done_err_d;
  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    imm_en_d     = imm_en_q;
    imm_d        = imm_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    done_valid_d = 1'b0;
    done_data_d  = done_data_q;
    done_err_d   = done_err_q;
    rf_d         = rf_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          op_d     = req_op;
          rs1_d    = req_rs1;
          rs2_d    = req_rs2;
          rd_d     = req_rd;
          imm_en_d = req_imm_en;
          imm_d    = req_imm;
          state_d  = StRead;
        end
      end
      StRead: begin
        // rf_q is the pre-edge value, so a cfg write on this same edge is not forwarded.
        alu_a_d    = (rs1_q == '0) ? '0 : rf_q[rs1_q];
        alu_b_d    = imm_en_q ? imm_q : ((rs2_q == '0) ? '0 : rf_q[rs2_q]);
        alu_ctrl_d = op_q;
        state_d    = StExec;
      end
      StExec: begin
        done_data_d  = alu_result;
        done_err_d   = ~op_legal(op_q);
        done_valid_d = 1'b1;  // pulse is visible during the WB cycle
        state_d      = StWb;
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    req_ready_d = (state_d == StIdle);

    if (cfg_we && (cfg_addr != '0)) begin
      rf_d[cfg_addr] = cfg_data;
    end
    // Applied after the cfg write so writeback wins a same-register collision.
    if ((state_q == StWb) && !done_err_q && (rd_q != '0)) begin
      rf_d[rd_q] = done_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b0;
      op_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      imm_en_q     <= 1'b0;
      imm_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      done_valid_q <= 1'b0;
      done_data_q  <= '0;
      done_err_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      op_q         <= op_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      imm_en_q     <= imm_en_d;
      imm_q        <= imm_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      done_valid_q <= done_valid_d;
      done_data_q  <= done_data_d;
      done_err_q   <= done_err_d;
      rf_q         <= rf_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign done_valid = done_valid_q;
  assign done_data  = done_data_q;
  assign done_err   = done_err_q;
  assign dbg_data   = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a transaction-timeline model of the register file and
// outputs is compared every cycle, plus literal expectations from the directed test plan.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [2:0]  req_rs1 = '0;
  logic [2:0]  req_rs2 = '0;
  logic        req_imm_en = 1'b0;
  logic [31:0] req_imm = '0;
  logic [2:0]  req_rd = '0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        done_valid, done_err;
  logic [31:0] done_data;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic [2:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int checks = 0;
  int failures = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  // Reference ALU; illegal codes return a ^ ~b so the captured value is still predictable.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    case (c)
      3'b000:  alu_fn = a + b;
      3'b001:  alu_fn = a - b;
      3'b010:  alu_fn = a & b;
      3'b011:  alu_fn = a ^ b;
      3'b101:  alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_fn = a ^ ~b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);

  alu_op_sequencer #(.WIDTH(32), .NREG(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm_en (req_imm_en),
    .req_imm    (req_imm),
    .req_rd     (req_rd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .done_valid (done_valid),
    .done_data  (done_data),
    .done_err   (done_err),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: one in-flight transaction on a timeline of edges ----------------
  logic [31:0] mrf [8];
  bit          m_ready = 1'b0;
  int          m_age = -1;     // edges since acceptance, -1 when idle
  logic [2:0]  t_op, t_rs1, t_rs2, t_rd;
  logic        t_ie;
  logic [31:0] t_imm;
  logic [31:0] m_a = '0, m_b = '0, m_data = '0;
  logic [2:0]  m_ctrl = '0;
  bit          m_err = 1'b0, m_done = 1'b0;

  initial begin
    bit acc;
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        m_ready = 0; m_age = -1; m_a = '0; m_b = '0; m_ctrl = '0;
        m_data = '0; m_err = 0; m_done = 0;
      end else begin
        acc = req_valid && m_ready;
        m_done = 0;
        if (m_age >= 0) m_age++;
        if (m_age == 1) begin
          m_a = mrf[t_rs1];
          m_b = t_ie ? t_imm : mrf[t_rs2];
          m_ctrl = t_op;
        end
        if (m_age == 2) begin
          m_data = alu_fn(m_a, m_b, m_ctrl);
          m_err = !(t_op inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd5});
          m_done = 1;
        end
        if (cfg_we && cfg_addr != 0) mrf[cfg_addr] = cfg_data;
        if (m_age == 3) begin
          if (!m_err && t_rd != 0) mrf[t_rd] = m_data;
          m_age = -1;
        end
        if (acc) begin
          t_op = req_op; t_rs1 = req_rs1; t_rs2 = req_rs2; t_rd = req_rd;
          t_ie = req_imm_en; t_imm = req_imm; m_age = 0;
        end
        m_ready = (m_age < 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (run_chk) begin
        chk("req_ready", req_ready, m_ready);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_ctrl", alu_ctrl, m_ctrl);
        chk("done_valid", done_valid, m_done);
        chk("done_data", done_data, m_data);
        chk("done_err", done_err, m_err);
        chk("dbg_data", dbg_data, mrf[dbg_addr]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 0;
  endtask

  task automatic dbg_chk(input logic [2:0] a, input logic [31:0] exp, input string nm);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, exp);
  endtask

  // Returns at the falling edge right after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic ie, input logic [31:0] imm, input logic [2:0] rd);
    int n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    chk("ready_wait", 32'(n < 50), 32'd1);
    req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_imm_en = ie; req_imm = imm; req_rd = rd;
    req_valid = 1;
    @(posedge clk);
    step();
    req_valid = 0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic ie, input logic [31:0] imm, input logic [2:0] rd,
                        input logic [31:0] exp_d, input logic exp_e, input string nm);
    int lat;
    send(op, rs1, rs2, ie, imm, rd);
    lat = 1;
    while (!done_valid && lat < 20) begin step(); lat++; end
    chk({nm, "_latency"}, lat, 32'd3);
    chk({nm, "_data"}, done_data, exp_d);
    chk({nm, "_err"}, done_err, exp_e);
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  acc_n, i, stamp [4];
    bit  fin;

    repeat (2) step();
    chk("rst_ready", req_ready, 32'd0);
    chk("rst_done_valid", done_valid, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    rst_n = 1;
    run_chk = 1;
    step();
    chk("ready_after_release", req_ready, 32'd1);

    // ADD r3 = r1 + r2
    cfg_wr(1, 20);
    cfg_wr(2, 10);
    run_op(3'b000, 1, 2, 0, 0, 3, 32'd30, 0, "add");
    dbg_chk(3, 32'd30, "add_r3");

    // SUB then SLT on the negative result
    cfg_wr(1, 10);
    cfg_wr(2, 20);
    run_op(3'b001, 1, 2, 0, 0, 4, 32'hFFFF_FFF6, 0, "sub");
    run_op(3'b101, 4, 0, 1, 32'd1, 5, 32'd1, 0, "slt");
    dbg_chk(5, 32'd1, "slt_r5");

    // XOR with rd = r0: result reported, nothing written
    cfg_wr(1, 20);
    run_op(3'b011, 1, 0, 1, 32'd1, 0, 32'd21, 0, "xor_r0");
    dbg_chk(0, 32'd0, "r0_zero");
    dbg_chk(1, 32'd20, "xor_r1_kept");
    cfg_wr(0, 32'd55);
    dbg_chk(0, 32'd0, "r0_cfg_ignored");

    // Illegal op: error flagged, no writeback, next legal op normal
    run_op(3'b111, 1, 2, 0, 0, 6, 32'hFFFF_FFFF, 1, "illegal");
    dbg_chk(6, 32'd0, "illegal_no_wb");
    run_op(3'b000, 1, 0, 1, 32'd5, 6, 32'd25, 0, "after_illegal");
    dbg_chk(6, 32'd25, "after_illegal_r6");

    // req_valid held high; fields scrambled while not ready
    cfg_wr(3, 0);
    acc_n = 0; fin = 0; i = 0;
    while (!fin && i < 60) begin
      if (req_ready) begin
        if (acc_n < 3) begin
          req_op = 3'b000; req_rs1 = 3; req_rs2 = 1; req_imm_en = 0; req_rd = 3;
          req_valid = 1; acc_n++; stamp[acc_n] = i;
        end else begin
          req_valid = 0; fin = 1;
        end
      end else begin
        req_op = 3'($urandom); req_rs1 = 3'($urandom); req_rs2 = 3'($urandom);
        req_rd = 3'($urandom); req_imm_en = 1'($urandom); req_imm = $urandom;
      end
      if (!fin) begin step(); i++; end
    end
    chk("chain_finished", 32'(fin), 32'd1);
    chk("chain_gap1", stamp[2] - stamp[1], 32'd4);
    chk("chain_gap2", stamp[3] - stamp[2], 32'd4);
    dbg_chk(3, 32'd60, "chain_r3");

    // cfg at READ edge not forwarded; cfg at WB edge loses to writeback
    send(3'b000, 1, 2, 0, 0, 2);
    cfg_we = 1; cfg_addr = 1; cfg_data = 32'd100;
    step();
    cfg_we = 0;
    step();
    chk("coll_done_valid", done_valid, 32'd1);
    chk("coll_data", done_data, 32'd40);
    cfg_we = 1; cfg_addr = 2; cfg_data = 32'd999;
    step();
    cfg_we = 0;
    dbg_chk(2, 32'd40, "coll_wb_wins");
    dbg_chk(1, 32'd100, "coll_cfg_r1");

    // Reset during EXEC
    send(3'b000, 1, 2, 0, 0, 7);
    step();
    #1 rst_n = 0;
    #1;
    chk("rst_exec_ready", req_ready, 32'd0);
    chk("rst_exec_alu_a", alu_a, 32'd0);
    chk("rst_exec_alu_b", alu_b, 32'd0);
    chk("rst_exec_ctrl", alu_ctrl, 32'd0);
    chk("rst_exec_done_valid", done_valid, 32'd0);
    chk("rst_exec_done_data", done_data, 32'd0);
    chk("rst_exec_done_err", done_err, 32'd0);
    repeat (2) step();
    chk("rst_exec_no_pulse", done_valid, 32'd0);
    rst_n = 1;
    step();
    chk("rst_exec_ready_back", req_ready, 32'd1);
    dbg_chk(7, 32'd0, "rst_exec_r7");
    dbg_chk(1, 32'd0, "rst_exec_r1");
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
